pls_feedback_decoder: RTL and testbench



---
 rtl/pls_feedback_decoder_if.sv | 22 ++
 rtl/pls_feedback_decoder.sv | 164 ++++++++++++++++
 tb/tb_pls_feedback_decoder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pls_feedback_decoder_if.sv
// Pin-side and feedback signals of the single-axis pulse-train receiver.
interface pls_feedback_decoder_if #(
    parameter int unsigned POS_W = 32
);
    logic                    plsMode;
    logic                    PlsIn;
    logic                    DirIn;
    logic                    clrPos;
    logic [15:0]             AxisPluse;
    logic                    frameFlag;
    logic signed [POS_W-1:0] position;

    modport master (
        output plsMode, PlsIn, DirIn, clrPos,
        input  AxisPluse, frameFlag, position
    );

    modport slave (
        input  plsMode, PlsIn, DirIn, clrPos,
        output AxisPluse, frameFlag, position
    );
endinterface

// File: rtl/pls_feedback_decoder.sv
// Pulse+dir / CW-CCW receiver: position accumulator plus per-frame Info/Value feedback word.
// Optional glitch filter on both pins enabled by defining PLS_DEC_GLITCH_EN.
module pls_feedback_decoder #(
    parameter int unsigned FRAME_CYCLES = 1600,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MIN_WIDTH    = 2,
    parameter int unsigned POS_W        = 32
) (
    input logic                   clk_4M,
    input logic                   rst,
    pls_feedback_decoder_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(FRAME_CYCLES);
    localparam logic [CntW-1:0] TermCnt = CntW'(FRAME_CYCLES - 1);

    if (SYNC_STAGES < 2 || MIN_WIDTH < 1) begin : g_param_err
        $error("pls_feedback_decoder: SYNC_STAGES must be >= 2 and MIN_WIDTH >= 1");
    end

    logic [SYNC_STAGES-1:0] r_pls_sync;
    logic [SYNC_STAGES-1:0] r_dir_sync;
    logic [1:0]             w_sync;
    logic [1:0]             w_filt;
    logic [1:0]             r_filt_prev;
    logic [1:0]             w_rise;

    logic                   r_mode;
    logic                   r_dir;
    logic                   r_fresh;
    logic                   r_seen_p;
    logic                   r_seen_m;
    logic                   r_flag;
    logic signed [9:0]      r_net;
    logic signed [9:0]      w_net_base;
    logic signed [9:0]      w_net_next;
    logic [9:0]             w_abs;
    logic [7:0]             w_mag;
    logic                   w_sat;
    logic                   w_dir;
    logic                   w_term;
    logic                   w_plus;
    logic                   w_minus;
    logic [CntW-1:0]        r_frame_cnt;
    logic [15:0]            r_word;
    logic [15:0]            w_word;
    logic [POS_W-1:0]       r_position;

    // Bit 0 carries the pulse/CW line, bit 1 the direction/CCW line.
    assign w_sync = {r_dir_sync[SYNC_STAGES-1], r_pls_sync[SYNC_STAGES-1]};

    always_ff @(posedge clk_4M) begin
        if (rst) begin
            r_pls_sync <= '0;
            r_dir_sync <= '0;
        end else begin
            r_pls_sync <= {r_pls_sync[SYNC_STAGES-2:0], bus.PlsIn};
            r_dir_sync <= {r_dir_sync[SYNC_STAGES-2:0], bus.DirIn};
        end
    end

`ifdef PLS_DEC_GLITCH_EN
    localparam int unsigned FiltW = $clog2(MIN_WIDTH + 1);

    logic [FiltW-1:0] r_filt_cnt [2];
    logic [1:0]       r_filt;

    always_ff @(posedge clk_4M) begin
        if (rst) begin
            r_filt        <= '0;
            r_filt_cnt[0] <= '0;
            r_filt_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_filt_cnt[i] <= '0;
                end else if (r_filt_cnt[i] == FiltW'(MIN_WIDTH - 1)) begin
                    r_filt[i]     <= w_sync[i];
                    r_filt_cnt[i] <= '0;
                end else begin
                    r_filt_cnt[i] <= r_filt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = w_sync;
`endif

    always_comb begin
        w_rise  = w_filt & ~r_filt_prev;
        w_plus  = 1'b0;
        w_minus = 1'b0;
        if (r_mode) begin
            w_plus  = w_rise[0];
            w_minus = w_rise[1];
        end else begin
            w_plus  = w_rise[0] & w_filt[1];
            w_minus = w_rise[0] & ~w_filt[1];
        end

        // A step in the terminal cycle belongs to the frame that starts next.
        w_term     = (r_frame_cnt == TermCnt);
        w_net_base = w_term ? 10'sd0 : r_net;
        w_net_next = w_net_base;
        if (w_plus && !w_minus && w_net_base != 10'sd511) begin
            w_net_next = w_net_base + 10'sd1;
        end else if (w_minus && !w_plus && w_net_base != -10'sd511) begin
            w_net_next = w_net_base - 10'sd1;
        end

        w_abs  = r_net[9] ? $unsigned(-r_net) : $unsigned(r_net);
        w_sat  = (w_abs > 10'd255);
        w_mag  = w_sat ? 8'hFF : w_abs[7:0];
        w_dir  = (r_net == 10'sd0) ? r_dir : ~r_net[9];
        w_word = {3'b000, r_seen_p & r_seen_m, w_sat, ~r_fresh, r_mode, w_dir, w_mag};
    end

    always_ff @(posedge clk_4M) begin
        if (rst) begin
            r_filt_prev <= '0;
            r_flag      <= 1'b0;
            r_net       <= '0;
            r_frame_cnt <= '0;
            r_position  <= '0;
            r_word      <= '0;
            r_dir       <= 1'b0;
            r_fresh     <= 1'b0;
            r_mode      <= 1'b0;
            r_seen_p    <= 1'b0;
            r_seen_m    <= 1'b0;
        end else begin
            r_filt_prev <= w_filt;
            r_flag      <= w_term;
            r_net       <= w_net_next;
            r_frame_cnt <= w_term ? '0 : r_frame_cnt + 1'b1;

            if (bus.clrPos) begin
                r_position <= '0;
            end else if (w_plus && !w_minus) begin
                r_position <= r_position + 1'b1;
            end else if (w_minus && !w_plus) begin
                r_position <= r_position - 1'b1;
            end

            if (w_term) begin
                r_word   <= w_word;
                r_dir    <= w_dir;
                r_fresh  <= ~r_fresh;
                r_mode   <= bus.plsMode;
                r_seen_p <= w_plus;
                r_seen_m <= w_minus;
            end else begin
                r_seen_p <= r_seen_p | w_plus;
                r_seen_m <= r_seen_m | w_minus;
            end
        end
    end

    assign bus.AxisPluse = r_word;
    assign bus.frameFlag = r_flag;
    assign bus.position  = r_position;
endmodule

// File: tb/tb_pls_feedback_decoder.sv
// Randomised bench for pls_feedback_decoder with a frame-level behavioural model.
module tb_pls_feedback_decoder;
    localparam int FRAME = 1600;
    localparam int SYNC  = 2;
    localparam int MW    = 2;
    localparam int POS_W = 32;
`ifdef PLS_DEC_GLITCH_EN
    localparam int LAT = SYNC + MW + 1;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    bit   chk_en;

    pls_feedback_decoder_if #(.POS_W(POS_W)) bus ();

    pls_feedback_decoder #(
        .FRAME_CYCLES(FRAME),
        .SYNC_STAGES (SYNC),
        .MIN_WIDTH   (MW),
        .POS_W       (POS_W)
    ) dut (
        .clk_4M(clk),
        .rst   (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int               m_cnt;
    int               m_net;
    bit               m_seenp, m_seenm, m_mode, m_dir, m_fresh, m_flag;
    logic [POS_W-1:0] m_pos;
    logic [15:0]      m_word;
    bit               hp [SYNC];
    bit               hd [SYNC];
    bit               fp_cur, fp_prev, fd_cur, fd_prev;
`ifdef PLS_DEC_GLITCH_EN
    bit               wp [MW];
    bit               wd [MW];
`endif

    task automatic model_step();
        bit rp, rd, plus, minus, allp, alld;
        int step, mag;
        if (rst) begin
            m_cnt = 0; m_net = 0; m_seenp = 0; m_seenm = 0; m_mode = 0; m_dir = 0;
            m_fresh = 0; m_flag = 0; m_pos = '0; m_word = '0;
            for (int i = 0; i < SYNC; i++) begin hp[i] = 0; hd[i] = 0; end
            fp_cur = 0; fp_prev = 0; fd_cur = 0; fd_prev = 0;
`ifdef PLS_DEC_GLITCH_EN
            for (int i = 0; i < MW; i++) begin wp[i] = 0; wd[i] = 0; end
`endif
            return;
        end
        rp = fp_cur & ~fp_prev;
        rd = fd_cur & ~fd_prev;
        if (m_mode) begin
            plus  = rp;
            minus = rd;
        end else begin
            plus  = rp & fd_cur;
            minus = rp & ~fd_cur;
        end
        step  = int'(plus) - int'(minus);
        m_pos = bus.clrPos ? '0 : m_pos + step;
        m_flag = (m_cnt == FRAME - 1);
        if (m_flag) begin
            mag = (m_net < 0) ? -m_net : m_net;
            if (m_net > 0) m_dir = 1;
            else if (m_net < 0) m_dir = 0;
            m_fresh = ~m_fresh;
            m_word  = {3'b000, m_seenp && m_seenm, mag > 255, m_fresh, m_mode, m_dir,
                       (mag > 255) ? 8'hFF : 8'(mag)};
            m_net   = step;
            m_seenp = plus;
            m_seenm = minus;
            m_mode  = bus.plsMode;
            m_cnt   = 0;
        end else begin
            m_net = m_net + step;
            if (m_net > 511) m_net = 511;
            if (m_net < -511) m_net = -511;
            m_seenp = m_seenp | plus;
            m_seenm = m_seenm | minus;
            m_cnt++;
        end
        // Input conditioning: pin delayed by SYNC samples, optionally debounced.
        fp_prev = fp_cur;
        fd_prev = fd_cur;
        for (int i = SYNC - 1; i > 0; i--) begin hp[i] = hp[i-1]; hd[i] = hd[i-1]; end
        hp[0] = bus.PlsIn;
        hd[0] = bus.DirIn;
`ifdef PLS_DEC_GLITCH_EN
        allp = 1;
        alld = 1;
        for (int i = 0; i < MW; i++) begin
            if (wp[i] == fp_cur) allp = 0;
            if (wd[i] == fd_cur) alld = 0;
        end
        if (allp) fp_cur = ~fp_cur;
        if (alld) fd_cur = ~fd_cur;
        for (int i = MW - 1; i > 0; i--) begin wp[i] = wp[i-1]; wd[i] = wd[i-1]; end
        wp[0] = hp[SYNC-1];
        wd[0] = hd[SYNC-1];
`else
        allp = 0;
        alld = 0;
        fp_cur = hp[SYNC-1] | allp;
        fd_cur = hd[SYNC-1] | alld;
`endif
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cyc_frameFlag", 32'(bus.frameFlag), 32'(m_flag));
            chk("cyc_AxisPluse", 32'(bus.AxisPluse), 32'(m_word));
            chk("cyc_position", bus.position, m_pos);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_flag(output int k);
        k = 0;
        while (!bus.frameFlag && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        chk("frame_flag_seen", 32'(bus.frameFlag), 32'd1);
    endtask

    task automatic pulses(input bit ccw, input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            if (ccw) bus.DirIn = 1'b1; else bus.PlsIn = 1'b1;
            repeat (hi) @(negedge clk);
            if (ccw) bus.DirIn = 1'b0; else bus.PlsIn = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic rand_cycle();
        if ($urandom_range(0, 3) == 0) bus.PlsIn = ~bus.PlsIn;
        if ($urandom_range(0, 5) == 0) bus.DirIn = ~bus.DirIn;
        bus.clrPos = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 799) == 0) bus.plsMode = ~bus.plsMode;
        @(negedge clk);
    endtask

    initial begin
        int k;
        n_total = 0;
        n_pass  = 0;
        chk_en  = 0;
        rst = 1'b1;
        bus.PlsIn = 1'b0;
        bus.DirIn = 1'b0;
        bus.plsMode = 1'b0;
        bus.clrPos = 1'b0;
        repeat (3) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        rst = 1'b0;

        // Idle frame after reset.
        wait_flag(k);
        chk("t1_flag_cycle", k, 32'd1600);
        chk("t1_word", 32'(bus.AxisPluse), 32'h0400);
        chk("t1_pos", bus.position, 32'd0);

        // Mode 0 forward then reverse; request CW/CCW for frame 3.
        bus.DirIn = 1'b1;
        pulses(0, 100, 4, 12);
        wait_flag(k);
        chk("t2_fwd_word", 32'(bus.AxisPluse), 32'h0164);
        chk("t2_fwd_pos", bus.position, 32'd100);
        bus.DirIn = 1'b0;
        bus.plsMode = 1'b1;
        pulses(0, 100, 4, 12);
        wait_flag(k);
        chk("t2_rev_word", 32'(bus.AxisPluse), 32'h0464);
        chk("t2_rev_pos", bus.position, 32'd0);

        // Mode 1: 30 CW, 10 CCW.
        pulses(0, 30, 4, 12);
        pulses(1, 10, 4, 12);
        bus.plsMode = 1'b0;
        wait_flag(k);
        chk("t3_word", 32'(bus.AxisPluse), 32'h1314);
        chk("t3_pos", bus.position, 32'd20);

        // Saturated frame value.
        bus.DirIn = 1'b1;
        pulses(0, 300, 2, 2);
        wait_flag(k);
        chk("t4_word", 32'(bus.AxisPluse), 32'h0DFF);
        chk("t4_pos", bus.position, 32'd320);

        // Clear, step to 2^32-1, wrap forward to 0.
        bus.clrPos = 1'b1;
        @(negedge clk);
        bus.clrPos = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_clr_pos", bus.position, 32'd0);
        bus.DirIn = 1'b0;
        repeat (8) @(negedge clk);
        pulses(0, 1, 4, 4);
        repeat (4) @(negedge clk);
        chk("t4_minus1_pos", bus.position, 32'hFFFF_FFFF);
        bus.DirIn = 1'b1;
        repeat (8) @(negedge clk);
        pulses(0, 1, 4, 4);
        repeat (4) @(negedge clk);
        chk("t4_wrap_pos", bus.position, 32'd0);

        // clrPos in the step cycle: position lost, frame still counts it.
        pulses(0, 3, 4, 4);
        chk("t5_pre_clr_pos", bus.position, 32'd3);
        bus.PlsIn = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        bus.clrPos = 1'b1;
        @(negedge clk);
        bus.clrPos = 1'b0;
        repeat (2) @(negedge clk);
        bus.PlsIn = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_clr_step_pos", bus.position, 32'd0);
`ifdef PLS_DEC_GLITCH_EN
        bus.PlsIn = 1'b1;
        @(negedge clk);
        bus.PlsIn = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_glitch_pos", bus.position, 32'd0);
`endif
        wait_flag(k);
        chk("t5_word", 32'(bus.AxisPluse), 32'h1104);

        // Random traffic with a mid-frame reset.
        repeat (300) rand_cycle();
        rst = 1'b1;
        repeat (2) rand_cycle();
        rst = 1'b0;
        k = 0;
        while (!bus.frameFlag && k < 2 * FRAME) begin
            rand_cycle();
            k++;
        end
        chk("rst_mid_flag_cycle", k, 32'd1600);
        repeat (3 * FRAME) rand_cycle();
        bus.clrPos = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
